// File: rtl/dds_multi.sv
// Multi-channel direct digital synthesizer: one shared waveform table, per-channel
// phase accumulators with run, burst and frequency-sweep modes.
module dds_multi #(
    parameter int DATA_LEN    = 8,
    parameter int ROWS_BASE_2 = 9,
    parameter int CHANNELS    = 2,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         src_clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [ROWS_BASE_2-1:0]       addr_wr,
    input  logic [DATA_LEN-1:0]          data_wr,
    input  logic                         cfg_we,
    input  logic [CH_W-1:0]              ch_sel,
    input  logic [2:0]                   cfg_addr,
    input  logic [31:0]                  cfg_data,
    output logic [CHANNELS*DATA_LEN-1:0] sinwave,
    output logic [CHANNELS-1:0]          busy,
    output logic [CHANNELS-1:0]          done
);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_BURST, ST_SWEEP} mode_t;

    localparam int DEPTH = 1 << ROWS_BASE_2;

    // Shared table is never reset; reads see the word stored before a same-edge write.
    logic [DATA_LEN-1:0] wave_mem [DEPTH];

    always_ff @(posedge src_clk) begin
        if (we) wave_mem[addr_wr] <= data_wr;
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        mode_t                  mode_q, mode_d;
        logic [31:0]            acc_q, acc_d, freq_q, freq_d, cur_q, cur_d;
        logic [31:0]            step_q, step_d, limit_q, limit_d;
        logic [ROWS_BASE_2-1:0] phase_q, phase_d, rd_addr;
        logic [15:0]            blen_q, blen_d, cnt_q, cnt_d, cnt_inc, blen_eff;
        logic [DATA_LEN-1:0]    sample_q;
        logic [32:0]            acc_sum, sweep_sum;
        logic                   done_q, done_d, wrap, sel, active;

        assign sel     = cfg_we && (ch_sel == CH_W'(ch));
        assign active  = (mode_q != ST_STOP);
        assign rd_addr = acc_q[31 -: ROWS_BASE_2] + phase_q;

        always_comb begin
            mode_d    = mode_q;
            acc_d     = acc_q;
            freq_d    = freq_q;
            cur_d     = cur_q;
            step_d    = step_q;
            limit_d   = limit_q;
            phase_d   = phase_q;
            blen_d    = blen_q;
            cnt_d     = cnt_q;
            done_d    = 1'b0;
            acc_sum   = {1'b0, acc_q} + {1'b0, cur_q};
            sweep_sum = {1'b0, cur_q} + {1'b0, step_q};
            cnt_inc   = cnt_q + 16'd1;
            blen_eff  = (blen_q == 16'd0) ? 16'd1 : blen_q;
            wrap      = active && acc_sum[32];

            if (active) acc_d = acc_sum[31:0];

            if (wrap) begin
                case (mode_q)
                    ST_BURST: begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= blen_eff) begin
                            done_d = 1'b1;
                            mode_d = ST_STOP;
                        end
                    end
                    ST_SWEEP: begin
                        if (!sweep_sum[32] && (sweep_sum[31:0] <= limit_q))
                            cur_d = sweep_sum[31:0];
                        else
                            cur_d = freq_q;
                    end
                    default: ;
                endcase
            end

            // A register write lands after the auto-stop so a mode write wins over it.
            if (sel) begin
                case (cfg_addr)
                    3'd0: begin
                        freq_d = cfg_data;
                        if (mode_q != ST_SWEEP) cur_d = cfg_data;
                    end
                    3'd1: phase_d = cfg_data[ROWS_BASE_2-1:0];
                    3'd2: begin
                        mode_d = mode_t'(cfg_data[1:0]);
                        if (mode_q == ST_STOP && cfg_data[1:0] != 2'd0) begin
                            acc_d = '0;
                            cnt_d = '0;
                            cur_d = freq_q;
                        end
                    end
                    3'd3: blen_d  = cfg_data[15:0];
                    3'd4: step_d  = cfg_data;
                    3'd5: limit_d = cfg_data;
                    default: ;
                endcase
            end
        end

        always_ff @(posedge src_clk or posedge rst) begin
            if (rst) begin
                mode_q   <= ST_STOP;
                acc_q    <= '0;
                freq_q   <= '0;
                cur_q    <= '0;
                step_q   <= '0;
                limit_q  <= '0;
                phase_q  <= '0;
                blen_q   <= '0;
                cnt_q    <= '0;
                done_q   <= 1'b0;
                sample_q <= '0;
            end else begin
                mode_q   <= mode_d;
                acc_q    <= acc_d;
                freq_q   <= freq_d;
                cur_q    <= cur_d;
                step_q   <= step_d;
                limit_q  <= limit_d;
                phase_q  <= phase_d;
                blen_q   <= blen_d;
                cnt_q    <= cnt_d;
                done_q   <= done_d;
                sample_q <= active ? wave_mem[rd_addr] : '0;
            end
        end

        assign sinwave[ch*DATA_LEN +: DATA_LEN] = sample_q;
        assign busy[ch] = active;
        assign done[ch] = done_q;
    end

endmodule

// File: tb/tb_dds_multi.sv
// Directed bench for dds_multi: ramp playback, phase offset, burst, sweep,
// asynchronous reset abort and read-during-write behaviour of the shared table.
module tb_dds_multi;

    localparam int DL  = 8;
    localparam int RB  = 9;
    localparam int CHN = 2;
    localparam int CW  = 1;

    logic            src_clk = 1'b0;
    logic            rst = 1'b0;
    logic            we = 1'b0;
    logic [RB-1:0]   addr_wr = '0;
    logic [DL-1:0]   data_wr = '0;
    logic            cfg_we = 1'b0;
    logic [CW-1:0]   ch_sel = '0;
    logic [2:0]      cfg_addr = '0;
    logic [31:0]     cfg_data = '0;
    logic [CHN*DL-1:0] sinwave;
    logic [CHN-1:0]  busy;
    logic [CHN-1:0]  done;
    logic [DL-1:0]   s0, s1;

    int checks = 0;
    int errors = 0;

    assign s0 = sinwave[7:0];
    assign s1 = sinwave[15:8];

    dds_multi #(.DATA_LEN(DL), .ROWS_BASE_2(RB), .CHANNELS(CHN), .CH_W(CW)) dut (
        .src_clk(src_clk), .rst(rst), .we(we), .addr_wr(addr_wr), .data_wr(data_wr),
        .cfg_we(cfg_we), .ch_sel(ch_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .sinwave(sinwave), .busy(busy), .done(done)
    );

    always #5 src_clk = ~src_clk;

    task automatic tick;
        @(posedge src_clk);
        #1;
    endtask

    task automatic cfg(input logic [CW-1:0] c, input logic [2:0] a, input logic [31:0] d);
        ch_sel   = c;
        cfg_addr = a;
        cfg_data = d;
        cfg_we   = 1'b1;
        tick;
        cfg_we   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] sw [1200];
    logic [7:0] rec [521];
    int run_val [$];
    int run_len [$];
    int done_cnt;
    logic [7:0] d;

    initial begin
        // reset state
        #2 rst = 1'b1;
        #1;
        check("rst_sinwave", 32'(sinwave), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick;
        tick;
        rst = 1'b0;

        // table[i] = i mod 256
        for (int i = 0; i < 512; i++) begin
            we = 1'b1;
            addr_wr = RB'(i);
            data_wr = DL'(i);
            tick;
        end
        we = 1'b0;

        // ramp on ch0, address wraps 511 -> 0
        cfg(0, 3'd0, 32'h0080_0000);
        cfg(0, 3'd2, 32'd1);
        for (int k = 0; k < 600; k++) begin
            tick;
            check("ramp", 32'(s0), 32'(k % 256));
        end
        check("ramp_busy", 32'(busy[0]), 32'd1);

        // stop: busy drops at once, output zero from the following cycle
        cfg(0, 3'd2, 32'd0);
        check("stop_busy", 32'(busy[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick;
            check("stop_zero", 32'(s0), 32'd0);
        end

        // phase offset: one cfg write per cycle, so ch1 gets one double-rate cycle to line up
        cfg(1, 3'd0, 32'h0080_0000);
        cfg(1, 3'd1, 32'd45);
        cfg(0, 3'd2, 32'd1);
        cfg(1, 3'd2, 32'd1);
        cfg(1, 3'd0, 32'h0100_0000);
        cfg(1, 3'd0, 32'h0080_0000);
        for (int k = 0; k < 300; k++) begin
            tick;
            check("phase_diff", 32'(8'(s1 - s0)), 32'd45);
        end
        cfg(0, 3'd2, 32'd0);
        cfg(1, 3'd2, 32'd0);

        // reserved register addresses change nothing
        cfg(0, 3'd6, 32'd1);
        cfg(0, 3'd7, 32'd1);
        tick;
        check("rsvd_busy", 32'(busy), 32'd0);
        check("rsvd_sin", 32'(sinwave), 32'd0);

        // burst of 3 wraps at freq 2^31: six samples, then done with busy low
        cfg(0, 3'd0, 32'h8000_0000);
        cfg(0, 3'd3, 32'd3);
        cfg(0, 3'd2, 32'd2);
        for (int k = 1; k <= 7; k++) begin
            tick;
            check("burst_done", 32'(done[0]), (k == 6) ? 32'd1 : 32'd0);
            check("burst_busy", 32'(busy[0]), (k < 6) ? 32'd1 : 32'd0);
            check("burst_sin", 32'(s0), 32'd0);
        end

        // reset mid-burst with phase 5 (samples = 5)
        cfg(0, 3'd1, 32'd5);
        cfg(0, 3'd2, 32'd2);
        tick;
        tick;
        tick;
        check("pre_rst_sin", 32'(s0), 32'd5);
        check("pre_rst_busy", 32'(busy[0]), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_sin", 32'(sinwave), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        tick;
        tick;
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (done != '0) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_stopped", 32'(busy), 32'd0);

        // restart after reset; table survives reset so samples are 5 again
        cfg(0, 3'd0, 32'h8000_0000);
        cfg(0, 3'd3, 32'd3);
        cfg(0, 3'd1, 32'd5);
        cfg(0, 3'd2, 32'd2);
        for (int k = 1; k <= 7; k++) begin
            tick;
            check("reburst_done", 32'(done[0]), (k == 6) ? 32'd1 : 32'd0);
            check("reburst_busy", 32'(busy[0]), (k < 6) ? 32'd1 : 32'd0);
            check("reburst_sin", 32'(s0), (k <= 6) ? 32'd5 : 32'd0);
        end

        // mode write on the completion cycle wins, done still pulses
        cfg(0, 3'd2, 32'd2);
        for (int k = 1; k <= 5; k++) tick;
        ch_sel = 0;
        cfg_addr = 3'd2;
        cfg_data = 32'd1;
        cfg_we = 1'b1;
        tick;
        cfg_we = 1'b0;
        check("prio_done", 32'(done[0]), 32'd1);
        check("prio_busy", 32'(busy[0]), 32'd1);
        tick;
        check("prio_done_off", 32'(done[0]), 32'd0);
        check("prio_still_run", 32'(busy[0]), 32'd1);
        check("prio_sin", 32'(s0), 32'd5);
        cfg(0, 3'd2, 32'd0);

        // sweep on ch1: per-cycle address step follows freq_cur / 2^23
        cfg(1, 3'd0, 32'h0080_0000);
        cfg(1, 3'd4, 32'h0080_0000);
        cfg(1, 3'd5, 32'h0200_0000);
        cfg(1, 3'd2, 32'd3);
        for (int k = 0; k < 1200; k++) begin
            tick;
            sw[k] = s1;
        end
        check("sweep_busy", 32'(busy[1]), 32'd1);
        for (int k = 0; k < 1199; k++) begin
            d = sw[k+1] - sw[k];
            if (run_val.size() == 0 || int'(d) != run_val[run_val.size()-1]) begin
                run_val.push_back(int'(d));
                run_len.push_back(1);
            end else begin
                run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
            end
        end
        check("sweep_runs", 32'(run_val.size()), 32'd5);
        while (run_val.size() < 5) begin
            run_val.push_back(0);
            run_len.push_back(0);
        end
        check("sweep_v0", 32'(run_val[0]), 32'd1);
        check("sweep_l0", 32'(run_len[0]), 32'd512);
        check("sweep_v1", 32'(run_val[1]), 32'd2);
        check("sweep_l1", 32'(run_len[1]), 32'd256);
        check("sweep_v2", 32'(run_val[2]), 32'd3);
        check("sweep_l2", 32'(run_len[2]), 32'd171);
        check("sweep_v3", 32'(run_val[3]), 32'd4);
        check("sweep_l3", 32'(run_len[3]), 32'd128);
        check("sweep_v4", 32'(run_val[4]), 32'd1);
        check("sweep_l4", 32'(run_len[4]), 32'd132);
        cfg(1, 3'd2, 32'd0);

        // write table[5] on the same edge that reads address 5
        cfg(0, 3'd0, 32'h0080_0000);
        cfg(0, 3'd1, 32'd0);
        cfg(0, 3'd2, 32'd1);
        for (int k = 0; k < 521; k++) begin
            if (k == 5) begin
                we = 1'b1;
                addr_wr = 9'd5;
                data_wr = 8'hAA;
            end
            tick;
            we = 1'b0;
            rec[k] = s0;
        end
        check("rdw_old", 32'(rec[5]), 32'd5);
        check("rdw_next", 32'(rec[6]), 32'd6);
        check("rdw_other", 32'(rec[261]), 32'd5);
        check("rdw_new", 32'(rec[517]), 32'hAA);
        cfg(0, 3'd2, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
